dmv_sequencer: RTL
==================

# dmv_sequencer

Sequencer for MPEG-2 dual-prime motion-vector syntax. For each macroblock it walks the horizontal then the vertical component through three fields: motion_code, motion_residual and dmvector. It owns the consume port of the bitstream shifter and takes motion_code from an external combinational VLC decoder. It decodes the fixed-length residual and the 1–2-bit dmvector field itself, and presents all six decoded fields, registered, to the motion-vector prediction stage.

## Interface
- R_SIZE_MAX, 8, maximum residual width in bits (f_code−1, f_code ≤ 9).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one macroblock decode; sampled only in IDLE.
- f_code  in  4  residual width r_size = f_code−1; latched at start; legal 1..9.
- dual_prime  in  1  parse the dmvector field per component; latched at start.
- win  in  16  shifter peek window, MSB = next bitstream bit.
- win_valid  in  1  win holds at least 16 valid bits.
- vlc_code  in  6  signed motion_code (−16..+16) decoded from win.
- vlc_len  in  4  motion_code codeword length, 1..11.
- vlc_err  in  1  win does not begin with a legal motion_code.
- consume  out  1  shifter advances by consume_len at this edge.
- consume_len  out  5  bits consumed (0 when consume=0).
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse: decode finished; fields valid.
- err  out  1  one-cycle pulse with done when vlc_err aborted the decode.
- mc_h, mc_v  out  6  signed motion_code per component.
- res_h, res_v  out  8  unsigned motion_residual per component.
- dmv_h, dmv_v  out  2  signed dmvector per component (−1, 0, +1).

## Operation
- States: IDLE, CODE, RESID, DMV, DONE. A component index t selects horizontal (0) or vertical (1).
- IDLE:
  - On start=1, latch f_code and dual_prime.
  - Clear t, all result registers and err.
  - Go to CODE.
- CODE (stalls while win_valid=0):
  - If vlc_err=1: set err, consume nothing, go to DONE.
  - Otherwise consume vlc_len bits and store vlc_code into mc[t].
  - Next state, in priority order: RESID if r_size≠0 and vlc_code≠0; else DMV if dual_prime; else advance.
- RESID (stalls while win_valid=0):
  - Store res[t] = win[15 -: r_size], zero-extended to 8 bits.
  - Consume r_size bits.
  - Next: DMV if dual_prime, else advance.
- DMV (stalls while win_valid=0):
  - win[15]=0 → dmv[t]=0, consume 1.
  - win[15:14]=10 → dmv[t]=+1, consume 2.
  - win[15:14]=11 → dmv[t]=−1, consume 2.
  - Then advance.
- Advance: if t=0, set t=1 and go to CODE; if t=1, go to DONE.
- DONE: assert done (and err if set) for exactly one cycle, busy=0, go to IDLE.
- Skipped fields keep their cleared value of 0.
- A component with mc=0 never has a residual.
- Result outputs hold until the next accepted start, which clears them the same edge it is accepted.
- f_code outside 1..9 is illegal input; behaviour is unspecified.

## Timing
- Reset: state IDLE, t=0; consume=0, consume_len=0, busy=0, done=0, err=0; all mc/res/dmv=0.
- rst overrides everything, including in mid-decode. The shifter is not rewound; the upstream parser resynchronises.
- consume and consume_len are combinational from state and win, and are gated by win_valid. At most one field is consumed per cycle.
- Each of CODE, RESID and DMV takes exactly 1 cycle when win_valid=1, and stalls with consume=0 otherwise.
- Latency from start being sampled to done = (number of field states visited) + 1 cycles, with no stalls:
  - Minimum is 3 (both components mc-only).
  - Maximum is 7 (all six fields present).
- start is ignored while busy=1 and in DONE. Back-to-back starts are accepted on the cycle after done.
- A result register updates at the same edge its consume is taken.

## Test plan
- **Minimal decode.** f_code=1, dual_prime=0; vlc (+3,len 4) then (−2,len 5).
  - Expect consumes 4 then 5; done 3 cycles after start.
  - Expect mc_h=+3, mc_v=−2; res and dmv all 0.
- **Full decode.** f_code=4, dual_prime=1. Horizontal: vlc (+1,len 2), win residual bits 101, dmv bits 11. Vertical: vlc (−5,len 7), residual 011, dmv bit 0.
  - Expect consume sequence 2,3,2,7,3,1; done at cycle 7.
  - Expect res_h=5, dmv_h=−1, res_v=3, dmv_v=0.
- **Zero motion code.** f_code=3, dual_prime=1; both vlc codes 0 (len 1); dmv bits 10 then 0.
  - Expect no RESID states visited; dmv_h=+1, dmv_v=0; done at cycle 5.
- **Stall.** Full-decode stimulus with win_valid=0 for 3 cycles while in RESID.
  - Expect consume=0 during the stall; results identical to the full decode; done 3 cycles later.
- **VLC error.** vlc_err=1 in the vertical CODE state.
  - Expect no consume on that cycle; done=1 and err=1 together one cycle later; mc_h retains its value; busy drops.
- **Reset mid-decode / ignored start.** rst asserted in DMV: all outputs go to 0 next cycle, and the next start runs a clean decode. A start pulse while busy=1 has no effect.

Source files
------------

// File: rtl/dmv_sequencer.sv
// dmv_sequencer: dual-prime motion-vector field sequencer.
// Walks motion_code, residual and dmvector for h then v.
module dmv_sequencer #(
  parameter int R_SIZE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            f_code,
  input  logic                  dual_prime,
  input  logic [15:0]           win,
  input  logic                  win_valid,
  input  logic [5:0]            vlc_code,
  input  logic [3:0]            vlc_len,
  input  logic                  vlc_err,
  output logic                  consume,
  output logic [4:0]            consume_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [5:0]            mc_h,
  output logic [5:0]            mc_v,
  output logic [R_SIZE_MAX-1:0] res_h,
  output logic [R_SIZE_MAX-1:0] res_v,
  output logic [1:0]            dmv_h,
  output logic [1:0]            dmv_v
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CODE,
    S_RESID,
    S_DMV,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic   t_q, t_d;
  logic   [3:0] fc_q, fc_d;
  logic   dp_q, dp_d;
  logic   err_q, err_d;

  logic [1:0][5:0]            mc_q, mc_d;
  logic [1:0][R_SIZE_MAX-1:0] res_q, res_d;
  logic [1:0][1:0]            dmv_q, dmv_d;

  logic [3:0]            r_size;
  logic [3:0]            shamt;
  logic [R_SIZE_MAX-1:0] win_top;
  logic [R_SIZE_MAX-1:0] resid;
  logic                  adv;
  logic                  unused_win;

  assign r_size  = fc_q - 4'd1;
  // Right-align the top r_size bits of the window.
  assign shamt   = 4'(R_SIZE_MAX) - r_size;
  assign win_top = win[15 -: R_SIZE_MAX];
  assign resid   = win_top >> shamt;

  assign unused_win = ^win[15-R_SIZE_MAX:0];

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    fc_d        = fc_q;
    dp_d        = dp_q;
    err_d       = err_q;
    mc_d        = mc_q;
    res_d       = res_q;
    dmv_d       = dmv_q;
    consume     = 1'b0;
    consume_len = 5'd0;
    adv         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          fc_d    = f_code;
          dp_d    = dual_prime;
          t_d     = 1'b0;
          err_d   = 1'b0;
          mc_d    = '0;
          res_d   = '0;
          dmv_d   = '0;
          state_d = S_CODE;
        end
      end
      S_CODE: begin
        if (win_valid) begin
          if (vlc_err) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            consume     = 1'b1;
            consume_len = {1'b0, vlc_len};
            mc_d[t_q]   = vlc_code;
            if (r_size != 4'd0 && vlc_code != 6'd0) begin
              state_d = S_RESID;
            end else if (dp_q) begin
              state_d = S_DMV;
            end else begin
              adv = 1'b1;
            end
          end
        end
      end
      S_RESID: begin
        if (win_valid) begin
          consume      = 1'b1;
          consume_len  = {1'b0, r_size};
          res_d[t_q]   = resid;
          if (dp_q) begin
            state_d = S_DMV;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_DMV: begin
        if (win_valid) begin
          consume = 1'b1;
          adv     = 1'b1;
          case (win[15:14])
            2'b10: begin
              dmv_d[t_q]  = 2'b01;
              consume_len = 5'd2;
            end
            2'b11: begin
              dmv_d[t_q]  = 2'b11;
              consume_len = 5'd2;
            end
            default: begin
              dmv_d[t_q]  = 2'b00;
              consume_len = 5'd1;
            end
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      if (t_q) begin
        state_d = S_DONE;
      end else begin
        t_d     = 1'b1;
        state_d = S_CODE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= 1'b0;
      fc_q    <= 4'd0;
      dp_q    <= 1'b0;
      err_q   <= 1'b0;
      mc_q    <= '0;
      res_q   <= '0;
      dmv_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      fc_q    <= fc_d;
      dp_q    <= dp_d;
      err_q   <= err_d;
      mc_q    <= mc_d;
      res_q   <= res_d;
      dmv_q   <= dmv_d;
    end
  end

  assign busy  = (state_q == S_CODE) || (state_q == S_RESID) ||
                 (state_q == S_DMV);
  assign done  = (state_q == S_DONE);
  assign err   = done & err_q;
  assign mc_h  = mc_q[0];
  assign mc_v  = mc_q[1];
  assign res_h = res_q[0];
  assign res_v = res_q[1];
  assign dmv_h = dmv_q[0];
  assign dmv_v = dmv_q[1];

endmodule
